// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack CDC handshake with an internal ack synchronizer.
// Define CDC_TX_TIMEOUT_EN to abort a request that sees no ack within TIMEOUT_CYCLES and flag err_o.
module cdc_handshake_tx #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             src_ready_o,
  output logic             xfer_req_o,
  output logic [WIDTH-1:0] xfer_data_o,
  input  logic             xfer_ack_i,
  output logic             done_o,
  output logic             err_o
);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state;
  logic [STAGES-1:0] ack_ff;
  logic ack_sync, timeout, abort;
  assign ack_sync = ack_ff[STAGES-1];
  assign src_ready_o = (state == IDLE) && !ack_sync;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) ack_ff <= '0;
    else ack_ff <= {ack_ff[STAGES-2:0], xfer_ack_i};
`ifdef CDC_TX_TIMEOUT_EN
  logic [15:0] cnt;
  assign timeout = (state == REQ) && !ack_sync && (cnt == 16'(TIMEOUT_CYCLES - 1));
  // abort remembers that the current DROP came from a timeout so no done pulse is issued
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      err_o <= 1'b0;
      abort <= 1'b0;
    end else begin
      cnt <= (state == REQ) ? cnt + 16'd1 : '0;
      err_o <= err_o | timeout;
      abort <= timeout ? 1'b1 : (state == IDLE) ? 1'b0 : abort;
    end
`else
  assign timeout = 1'b0;
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      xfer_req_o <= 1'b0;
      xfer_data_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (src_valid_i && src_ready_o) begin
          xfer_data_o <= src_data_i;
          xfer_req_o <= 1'b1;
          state <= REQ;
        end
        REQ: if (ack_sync || timeout) begin
          xfer_req_o <= 1'b0;
          state <= DROP;
        end
        DROP: if (!ack_sync) begin
          state <= IDLE;
          done_o <= !abort;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed bench with a scoreboard queue checked by a destination-side monitor.
module tb_cdc_handshake_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic src_valid_i = 1'b0;
  logic [7:0] src_data_i = '0;
  logic src_ready_o, xfer_req_o, xfer_ack_i, done_o, err_o;
  logic [7:0] xfer_data_o;
  int tests = 0, fails = 0, done_cnt = 0, rx_cnt = 0;
  bit dest_en = 0;
  logic [7:0] exp_q[$];
  always #5 clk = ~clk;
  cdc_handshake_tx #(.WIDTH(8), .STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .src_valid_i(src_valid_i), .src_data_i(src_data_i),
    .src_ready_o(src_ready_o), .xfer_req_o(xfer_req_o), .xfer_data_o(xfer_data_o),
    .xfer_ack_i(xfer_ack_i), .done_o(done_o), .err_o(err_o)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // monitor: pops the expected word on each req rise and checks data is held while req is high
  initial begin
    logic prev_req;
    logic [7:0] held;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_req = 1'b0;
        continue;
      end
      if (xfer_req_o && !prev_req) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got %0h expected no transfer", xfer_data_o);
        end else check("rx_data", xfer_data_o, exp_q.pop_front());
        rx_cnt++;
        held = xfer_data_o;
      end else if (xfer_req_o) check("data_hold", xfer_data_o, held);
      if (done_o) begin
        done_cnt++;
        check("done_ready", src_ready_o, 1);
      end
      prev_req = xfer_req_o;
    end
  end
  // destination model: ack follows req three cycles later
  initial begin
    int dcnt;
    dcnt = 0;
    forever begin
      @(negedge clk);
      if (dest_en) begin
        if (xfer_req_o != xfer_ack_i) begin
          dcnt++;
          if (dcnt == 3) begin
            xfer_ack_i = xfer_req_o;
            dcnt = 0;
          end
        end else dcnt = 0;
      end
    end
  end
  initial begin
    int bud;
    xfer_ack_i = 1'b0;
    #3;
    check("rst_req", xfer_req_o, 0);
    check("rst_data", xfer_data_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ready", src_ready_o, 1);
    #20 rstn = 1'b1;
    tick;
    check("post_rst_req", xfer_req_o, 0);
    check("post_rst_ready", src_ready_o, 1);
    src_valid_i = 1'b1;
    src_data_i = 8'hA5;
    exp_q.push_back(8'hA5);
    tick;
    check("a5_req_rise", xfer_req_o, 1);
    check("a5_data", xfer_data_o, 8'hA5);
    src_data_i = 8'h3C;
    exp_q.push_back(8'h3C);
    tick;
    tick;
    check("busy_ready", src_ready_o, 0);
    check("busy_data", xfer_data_o, 8'hA5);
    xfer_ack_i = 1'b1;
    tick;
    check("req_edge1", xfer_req_o, 1);
    tick;
    check("req_edge2", xfer_req_o, 1);
    tick;
    check("req_fall_edge3", xfer_req_o, 0);
    tick;
    tick;
    check("drop_ready", src_ready_o, 0);
    xfer_ack_i = 1'b0;
    tick;
    check("drop_done1", done_o, 0);
    tick;
    check("drop_done2", done_o, 0);
    check("drop_data", xfer_data_o, 8'hA5);
    tick;
    check("a5_done", done_o, 1);
    check("a5_done_ready", src_ready_o, 1);
    tick;
    check("done_width", done_o, 0);
    check("3c_accept", xfer_data_o, 8'h3C);
    check("3c_req", xfer_req_o, 1);
    src_valid_i = 1'b0;
    tick;
    xfer_ack_i = 1'b1;
    tick;
    tick;
    tick;
    check("3c_req_fall", xfer_req_o, 0);
    xfer_ack_i = 1'b0;
    tick;
    tick;
    tick;
    check("3c_done", done_o, 1);
    src_valid_i = 1'b1;
    src_data_i = 8'h77;
    exp_q.push_back(8'h77);
    tick;
    src_valid_i = 1'b0;
    check("77_req", xfer_req_o, 1);
    xfer_ack_i = 1'b1;
    tick;
    #2 rstn = 1'b0;
    #1;
    check("midrst_req", xfer_req_o, 0);
    check("midrst_data", xfer_data_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_ready", src_ready_o, 1);
    #3 rstn = 1'b1;
    tick;
    tick;
    tick;
    check("ack_high_ready", src_ready_o, 0);
    xfer_ack_i = 1'b0;
    tick;
    check("ack_drop_edge1", src_ready_o, 0);
    tick;
    check("ack_drop_edge2", src_ready_o, 1);
    check("midrst_no_done", done_cnt, 2);
    dest_en = 1;
    src_valid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      src_data_i = 8'(i);
      exp_q.push_back(8'(i));
      bud = 0;
      while (!src_ready_o && bud < 100) begin
        tick;
        bud++;
      end
      check("b2b_ready", src_ready_o, 1);
      tick;
    end
    src_valid_i = 1'b0;
    bud = 0;
    while (done_cnt < 6 && bud < 100) begin
      tick;
      bud++;
    end
    tick;
    check("b2b_done_cnt", done_cnt, 6);
    check("b2b_rx_cnt", rx_cnt, 7);
    dest_en = 0;
`ifdef CDC_TX_TIMEOUT_EN
    src_valid_i = 1'b1;
    src_data_i = 8'h5A;
    exp_q.push_back(8'h5A);
    tick;
    src_valid_i = 1'b0;
    check("to_req", xfer_req_o, 1);
    repeat (15) tick;
    check("to_req_before", xfer_req_o, 1);
    check("to_err_before", err_o, 0);
    tick;
    check("to_req_fall", xfer_req_o, 0);
    check("to_err", err_o, 1);
    tick;
    check("to_no_done", done_o, 0);
    check("to_ready", src_ready_o, 1);
    tick;
    tick;
    check("to_err_sticky", err_o, 1);
    check("to_done_cnt", done_cnt, 6);
`else
    check("err_tied", err_o, 0);
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
